// File: rtl/mem_bus_arbiter_if.sv
// Memory bus bundle shared by the CPU, DMA and memory sides
// of the two-master arbiter.
interface mem_bus_arbiter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  width;
  logic        read;
  logic        write;
  logic [31:0] rdata;
  logic        ok;
  logic        err;

  modport master (
    output addr, wdata, width, read, write,
    input  rdata, ok, err
  );

  modport slave (
    input  addr, wdata, width, read, write,
    output rdata, ok, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the single memory port: serialises,
// forwards and completes transactions, with DMA locking.
module mem_bus_arbiter #(
  parameter int DMA_FIRST = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  mem_bus_arbiter_if.slave          cpu,
  mem_bus_arbiter_if.slave          dma,
  mem_bus_arbiter_if.master         mem,
  input  logic                      dma_lock,
  output logic [1:0]                owner
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_BUSY,
    DMA_BUSY,
    DMA_HELD
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  state_t      state_nx;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nx;

  logic cpu_req;
  logic dma_req;
  logic cpu_bad;
  logic dma_bad;
  logic tmo;
  logic busy;
  logic unused_err;

  assign cpu_req = cpu.read | cpu.write;
  assign dma_req = dma.read | dma.write;
  assign cpu_bad = (cpu.width == 2'd3) |
                   (cpu.read & cpu.write);
  assign dma_bad = (dma.width == 2'd3) |
                   (dma.read & dma.write);
  assign tmo     = (wait_cnt == TMO) & ~mem.ok;
  assign busy    = (state == CPU_BUSY) |
                   (state == DMA_BUSY);

  // the memory side has no error return of its own
  assign unused_err = mem.err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    owner     = 2'b00;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.width = '0;
    mem.read  = 1'b0;
    mem.write = 1'b0;
    cpu.ok    = 1'b0;
    cpu.err   = 1'b0;
    cpu.rdata = '0;
    dma.ok    = 1'b0;
    dma.err   = 1'b0;
    dma.rdata = '0;

    unique case (state)
      IDLE: begin
        if (cpu_req && dma_req) begin
          state_nx = (DMA_FIRST != 0) ?
                     DMA_BUSY : CPU_BUSY;
        end else if (cpu_req) begin
          state_nx = CPU_BUSY;
        end else if (dma_req) begin
          state_nx = DMA_BUSY;
        end
      end

      CPU_BUSY: begin
        owner     = 2'b01;
        mem.addr  = cpu.addr;
        mem.wdata = cpu.wdata;
        mem.width = cpu.width;
        mem.read  = cpu.read & ~cpu_bad;
        mem.write = cpu.write & ~cpu_bad;
        cpu.ok    = ~cpu_bad & mem.ok;
        cpu.err   = cpu_bad | tmo;
        cpu.rdata = (~cpu_bad & mem.ok) ?
                    mem.rdata : '0;
        if (cpu.ok || cpu.err) begin
          state_nx = dma_req ? DMA_BUSY : IDLE;
        end
      end

      DMA_BUSY: begin
        owner     = 2'b10;
        mem.addr  = dma.addr;
        mem.wdata = dma.wdata;
        mem.width = dma.width;
        mem.read  = dma.read & ~dma_bad;
        mem.write = dma.write & ~dma_bad;
        dma.ok    = ~dma_bad & mem.ok;
        dma.err   = dma_bad | tmo;
        dma.rdata = (~dma_bad & mem.ok) ?
                    mem.rdata : '0;
        if (dma.ok || dma.err) begin
          if (dma_lock) begin
            state_nx = DMA_HELD;
          end else if (cpu_req) begin
            state_nx = CPU_BUSY;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      DMA_HELD: begin
        owner = 2'b10;
        if (dma_req) begin
          state_nx = DMA_BUSY;
        end else if (!dma_lock) begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // each BUSY stint is exactly one transaction
  always_comb begin
    wait_nx = wait_cnt;
    if (state_nx != state) begin
      wait_nx = '0;
    end else if (busy && !mem.ok) begin
      wait_nx = wait_cnt + 16'd1;
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the single system memory port between the ARMv4T CPU core and the DMA engine. It sits between both bus masters and the memory/peripheral interconnect. It serialises their read/write transactions, forwards each granted transaction unchanged, and routes the completion back to the originating master. It also supports DMA bus locking, rejects illegal requests, and aborts transactions that never complete.

## Interface
Parameters:
- DMA_FIRST, default 1: on a simultaneous fresh request from idle, 1 grants the DMA engine and 0 grants the CPU.
- TIMEOUT, default 255: maximum number of cycles a granted transaction waits for mem_ok before it is aborted. Legal range 1–65535.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low; clock clk.
- cpu_addr / dma_addr  in  32  byte address.
- cpu_wdata / dma_wdata  in  32  write data.
- cpu_width / dma_width  in  2  log2 of the access size in bytes; 0, 1 and 2 are legal, 3 is illegal.
- cpu_read / dma_read  in  1  read request.
- cpu_write / dma_write  in  1  write request.
- cpu_rdata / dma_rdata  out  32  read data; valid in the cycle the matching ok is high, 0 otherwise.
- cpu_ok / dma_ok  out  1  one-cycle completion pulse.
- cpu_err / dma_err  out  1  one-cycle error pulse; signals either a rejected request or a timeout.
- dma_lock  in  1  DMA requests to keep ownership between its transactions.
- mem_addr  out  32  forwarded address.
- mem_wdata  out  32  forwarded write data.
- mem_width  out  2  forwarded access width.
- mem_read  out  1  forwarded read strobe.
- mem_write  out  1  forwarded write strobe.
- mem_rdata  in  32  read data from memory.
- mem_ok  in  1  memory completion; may already be high in the first cycle of a transaction.
- owner  out  2  current owner: 00 none, 01 CPU, 10 DMA.

## Operation
- States: IDLE, CPU_BUSY, DMA_BUSY, DMA_HELD.
- Request protocol for each master:
  - A request is a high read or write strobe.
  - addr, width and wdata stay stable until ok or err is returned.
  - The master drops the strobe in the cycle after ok/err or later.
- IDLE:
  - If only one master requests, go to its BUSY state.
  - If both request, DMA_FIRST selects the winner.
  - If neither requests, stay in IDLE.
- BUSY state:
  - The owner's addr, width, wdata and strobes are forwarded to the mem_* outputs.
  - mem_ok is routed to the owner's ok output.
  - mem_rdata is routed to the owner's rdata output.
  - The other master's ok, err and rdata outputs are all 0.
- Illegal request (width 3, or read and write both high):
  - Rejected in the first BUSY cycle.
  - mem_read and mem_write stay 0; no memory access is made.
  - The owner's err pulses for one cycle.
  - This counts as a completion.
- Timeout:
  - A 16-bit wait counter clears on entry to any BUSY state and increments each cycle while mem_ok is low.
  - In the cycle where the counter equals TIMEOUT and mem_ok is low:
    - err pulses;
    - the mem strobes are deasserted from the next cycle;
    - this counts as a completion.
- On completion (ok or err) the next state is chosen as follows, ignoring the completing master's strobe in that cycle:
  - DMA completing with dma_lock high: go to DMA_HELD.
  - Otherwise, if the other master requests: go to its BUSY state. The two masters therefore alternate, with no bubble.
  - Otherwise: go to IDLE.
- DMA_HELD:
  - No memory strobes are driven; owner reads 10.
  - A DMA strobe sends the arbiter to DMA_BUSY.
  - dma_lock low sends it to IDLE. That IDLE cycle re-arbitrates normally in the following cycle.
  - CPU requests are held off while in DMA_HELD.
- In IDLE and DMA_HELD all mem_* outputs are 0.

## Timing
- The state register updates on the clk rising edge. All other outputs are combinational from state, the requester inputs, mem_ok and mem_rdata.
- Reset:
  - rstn low at an edge forces IDLE, and clears the wait counter.
  - From that cycle on every output is 0 and owner is 00.
  - A transaction in flight is dropped without ok or err. Its master is reset alongside.
- Latency:
  - A request first seen in IDLE in cycle N drives the mem_* outputs from cycle N+1.
  - With a zero-wait memory, ok arrives in cycle N+1.
  - A back-to-back handover costs 0 cycles.
- ok and err are never both high, and each pulse lasts exactly one cycle per transaction.

## Test plan
- Single-master read:
  - Stimulus: CPU read of 0x08000000 from idle; memory returns 0xE3A00001 with mem_ok two cycles after mem_read rises.
  - Required: cpu_ok pulses once and cpu_rdata is 0xE3A00001 in that cycle; dma_ok stays 0; owner goes 01 then 00.
- Contention and alternation:
  - Stimulus: CPU and DMA request in the same cycle with DMA_FIRST=1, both keep requesting, zero-wait memory.
  - Required: grants go DMA, CPU, DMA, CPU with no idle cycle between them.
- Locked DMA burst:
  - Stimulus: dma_lock high over 4 DMA writes while the CPU requests continuously.
  - Required: the CPU is not granted until the cycle after dma_lock drops; owner stays 10 throughout the DMA_HELD gaps.
- Illegal request:
  - Stimulus: DMA request with width 3.
  - Required: dma_err pulses in the first DMA_BUSY cycle; mem_read and mem_write are never asserted.
- Timeout:
  - Stimulus: TIMEOUT=4 and a memory that never asserts mem_ok.
  - Required: cpu_err pulses in the 5th BUSY cycle; mem strobes are low afterwards; the arbiter returns to IDLE.
- Reset mid-transaction:
  - Stimulus: rstn pulled low during the 2nd cycle of a DMA write.
  - Required: the next cycle has all outputs 0 and no dma_ok or dma_err; a subsequent CPU read completes normally.
